dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 64-bit words of storage; SHALL be a power of two, range 2..4096.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid; SHALL be in the range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  CPU-side load/store request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  64  byte address.
REQ-009 req_wdata  input  64  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  CPU accepts the response.
REQ-012 rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 Acceptance SHALL occur on an edge where req_valid=1 and req_ready=1; at that edge the block SHALL capture req_write, req_addr and req_wdata and load the latency counter with LATENCY-1.
REQ-017 Transition from IDLE: if LATENCY=1, go to RESP; otherwise go to WAIT.
REQ-018 In WAIT the counter SHALL decrement each cycle and the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-019 rsp_valid SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-020 Error condition: captured addr[2:0] != 0, or addr[63:3] >= DEPTH.
REQ-021 On the edge entering RESP with no error:
  - store: the storage word at index addr[log2(DEPTH)+2:3] SHALL be written with wdata, all 64 bits;
  - load: rsp_rdata SHALL be registered from that word.
REQ-022 On an error: no storage write, rsp_err=1, rsp_rdata=0.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-024 On an edge with rsp_valid=1 and rsp_ready=1:
  - the FSM SHALL return to IDLE;
  - rsp_valid, rsp_err and rsp_rdata SHALL clear to 0.
REQ-025 A new request SHALL NOT be accepted in the same cycle as the response handshake; minimum spacing between accepts is LATENCY+1 cycles.
REQ-026 req_* inputs are ignored outside IDLE; a load issued after a store to the same word SHALL return the stored value.
REQ-027 Storage contents are undefined after power-up and are not cleared by reset.

Reset
REQ-028 While reset=1 (asynchronous assertion):
  - state=IDLE, counter=0;
  - rsp_valid=0, rsp_err=0, rsp_rdata=0;
  - req_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-029 Reset in WAIT SHALL abort the request with no storage write; reset in RESP SHALL drop the response, and a store already committed stays committed.

Structure
REQ-030 Shared package dmem_pkg SHALL hold:
  - the state enum (IDLE/WAIT/RESP);
  - word width 64;
  - address width 64;
  - the alignment mask constant.
REQ-031 Storage SHALL be the sub-module dmem_array (DEPTH x 64, one synchronous write port, one synchronous read port); FSM, counter and error check stay in dmem_responder.

Verification
REQ-032 Aligned store then load (LATENCY=2): store addr 0x10, wdata 0xDEADBEEFCAFEF00D, rsp_ready=1 -> rsp_valid 2 cycles after accept with rsp_err=0; then load 0x10 -> rsp_rdata 0xDEADBEEFCAFEF00D.
REQ-033 Misaligned load addr 0x13 -> rsp_err=1, rsp_rdata=0; a subsequent load of 0x10 still returns its old value.
REQ-034 Out-of-range store addr 0x800 (DEPTH=256) -> rsp_err=1; index 0 is unchanged.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
REQ-036 Reset asserted in WAIT during store 0x20 (LATENCY=4) -> rsp_valid never rises; a later load of 0x20 returns the pre-store value.
REQ-037 LATENCY=1 load -> rsp_valid exactly 1 cycle after accept; back-to-back requests with rsp_ready=1 accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned ADDR_W = 64;

  // Byte-offset bits that must be zero for a 64-bit aligned access.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 64'h0000_0000_0000_0007;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage with one synchronous write port and one synchronous read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder in front of a dmem_array, with
// alignment/range error reporting and a valid/ready response handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept;
  logic              enter_resp;
  logic              rsp_hs;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_err;

  logic              err_q;
  logic              load_ok_q;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_hs    = rsp_valid && rsp_ready;

  // With LATENCY=1 the RESP entry coincides with acceptance, so the live
  // request is used instead of the not-yet-captured copy.
  always_comb begin
    cur_write = cap_write;
    cur_addr  = cap_addr;
    cur_wdata = cap_wdata;
    if (state == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign cur_err = (|(cur_addr & ALIGN_MASK)) || (|(cur_addr >> (IDX_W + 3)));

  always_comb begin
    state_nx   = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q     <= cur_err;
        load_ok_q <= !cur_write && !cur_err;
      end else if (rsp_hs) begin
        err_q     <= 1'b0;
        load_ok_q <= 1'b0;
      end
    end
  end

  // The array's read register is not reset; load_ok_q masks it so the
  // response data reads zero for stores, errors and after reset.
  assign arr_we    = enter_resp && cur_write && !cur_err && !reset;
  assign arr_re    = enter_resp && !cur_write && !cur_err && !reset;
  assign arr_idx   = cur_addr[IDX_W+2:3];
  assign rsp_err   = err_q;
  assign rsp_rdata = load_ok_q ? arr_rdata : '0;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_idx),
    .wdata (cur_wdata),
    .re    (arr_re),
    .raddr (arr_idx),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 4, 1) share
// the request bus; sel chooses which one is driven and observed.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  int          sel = 0;

  logic        d_req_ready [3];
  logic        d_rsp_valid [3];
  logic        d_rsp_err   [3];
  logic [63:0] d_rsp_rdata [3];

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [63:0] o_rsp_rdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [3][256];
  int          lat [3] = '{2, 4, 1};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0), .req_ready(d_req_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d_rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(d_rsp_rdata[0]),
    .rsp_err(d_rsp_err[0])
  );

  dmem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1), .req_ready(d_req_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d_rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(d_rsp_rdata[1]),
    .rsp_err(d_rsp_err[1])
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2), .req_ready(d_req_ready[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d_rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(d_rsp_rdata[2]),
    .rsp_err(d_rsp_err[2])
  );

  always_comb begin
    o_req_ready = d_req_ready[sel];
    o_rsp_valid = d_rsp_valid[sel];
    o_rsp_err   = d_rsp_err[sel];
    o_rsp_rdata = d_rsp_rdata[sel];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (dut %0d): observed=%h expected=%h", tag, sel, obs, exp);
    end
  endtask

  // Reference behaviour: error on misalignment or word index >= 256,
  // zero data for stores/errors, and stores update the model memory.
  task automatic predict(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                         output exp_t e);
    e.err   = (addr[2:0] != 3'd0) || ((addr >> 3) >= 64'd256);
    e.rdata = (wr || e.err) ? 64'd0 : model[sel][addr[10:3]];
    if (wr && !e.err) model[sel][addr[10:3]] = wd;
  endtask

  task automatic xact(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                      input int hold);
    exp_t e;
    int   n;
    predict(wr, addr, wd, e);
    sb.push_back(e);
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    chk("req_ready_idle", o_req_ready, 1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
    end while (!o_rsp_valid && n < 40);
    chk("latency", n, lat[sel]);
    e = sb.pop_front();
    chk("rsp_rdata", o_rsp_rdata, e.rdata);
    chk("rsp_err", o_rsp_err, e.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", o_rsp_valid, 1);
      chk("bp_rdata", o_rsp_rdata, e.rdata);
      chk("bp_err", o_rsp_err, e.err);
      chk("bp_req_ready", o_req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", o_rsp_valid, 0);
    chk("post_hs_rdata", o_rsp_rdata, 0);
    chk("post_hs_err", o_rsp_err, 0);
    chk("post_hs_req_ready", o_req_ready, 1);
  endtask

  initial begin
    exp_t e;
    logic saw;
    int   last_acc;
    int   n_acc;

    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_release_req_ready", o_req_ready, 1);

    // LATENCY=2: store/load, misaligned, out of range, boundary word, backpressure
    sel = 0;
    xact(1'b1, 64'h0,    64'h1111_2222_3333_4444, 0);
    xact(1'b1, 64'h10,   64'hDEAD_BEEF_CAFE_F00D, 0);
    xact(1'b0, 64'h10,   64'h0, 0);
    xact(1'b0, 64'h13,   64'h0, 0);
    xact(1'b0, 64'h10,   64'h0, 0);
    xact(1'b1, 64'h800,  64'h5555_AAAA_5555_AAAA, 0);
    xact(1'b0, 64'h0,    64'h0, 0);
    xact(1'b1, 64'h7F8,  64'h0123_4567_89AB_CDEF, 0);
    xact(1'b0, 64'h7F8,  64'h0, 0);
    xact(1'b0, 64'h7FC,  64'h0, 0);
    xact(1'b0, 64'h10,   64'h0, 5);

    // LATENCY=4: reset while in WAIT aborts the store
    sel = 1;
    xact(1'b1, 64'h20, 64'hA5A5_0000_1234_5678, 0);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hFFFF_EEEE_DDDD_CCCC;
    req_valid = 1'b1;
    chk("abort_req_ready", o_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_rst_req_ready", o_req_ready, 0);
    chk("abort_rst_rsp_valid", o_rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_release_req_ready", o_req_ready, 1);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw = saw | o_rsp_valid;
    end
    chk("abort_no_rsp", saw, 0);
    xact(1'b0, 64'h20, 64'h0, 0);

    // LATENCY=1: single transactions, then back-to-back loads with rsp_ready held
    sel = 2;
    xact(1'b1, 64'h10, 64'h0BAD_F00D_1357_9BDF, 0);
    xact(1'b0, 64'h10, 64'h0, 0);
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 64'h10;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    last_acc  = -1;
    n_acc     = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_rsp_valid) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("b2b_rdata", o_rsp_rdata, e.rdata);
          chk("b2b_err", o_rsp_err, e.err);
        end else begin
          chk("b2b_unexpected_rsp", o_rsp_valid, 0);
        end
      end
      if (o_req_ready) begin
        if (last_acc >= 0) chk("b2b_spacing", c - last_acc, 2);
        last_acc = c;
        n_acc++;
        predict(1'b0, 64'h10, 64'h0, e);
        sb.push_back(e);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_accepts", n_acc, 5);
    chk("b2b_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
